// File: rtl/flop_chk_pkg.sv
// Shared state encoding and default sizing for the flop response checker.
package flop_chk_pkg;

    localparam int unsigned DEF_CW    = 16;
    localparam int unsigned DEF_GUARD = 1;
    localparam int unsigned GUARD_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GUARD   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_SETHOLD = 2'd3
    } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import flop_chk_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          async_reset_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // Next count: hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flop_response_checker.sv
// Watches an async-set D flop and flags cycles where its q departs from a reference model.
module flop_response_checker
    import flop_chk_pkg::*;
#(
    parameter int unsigned GUARD = DEF_GUARD,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          async_reset_n,
    input  logic          chk_en,
    input  logic          clr,
    input  logic          obs_set,
    input  logic          obs_d,
    input  logic          obs_q,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] set_count,
    output logic [CW-1:0] first_err_cycle,
    output logic [1:0]    state
);

    localparam logic [GUARD_W-1:0] GUARD_LD   = GUARD_W'(GUARD);
    localparam bit                 GUARD_ZERO = (GUARD == 0);

    chk_state_e         state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               m_q, m_d;
    logic               set_prev_q, set_prev_d;
    logic               err_q, err_d;
    logic [CW-1:0]      first_err_cycle_q, first_err_cycle_d;
    logic [CW-1:0]      cycle_count_q, cycle_count_d;
    logic               cmp_en;
    logic               cmp_exp;
    logic               mismatch;
    logic               set_rise;

    // Next state, guard countdown and compare qualification.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        cmp_en  = 1'b0;
        cmp_exp = m_q;
        case (state_q)
            ST_IDLE: begin
                state_d = GUARD_ZERO ? ST_CHECK : ST_GUARD;
                guard_d = GUARD_LD;
            end
            ST_GUARD: begin
                guard_d = guard_q - GUARD_W'(1);
                if (guard_q <= GUARD_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cmp_en = 1'b1;
                if (obs_set) begin
                    state_d = ST_SETHOLD;
                end
            end
            ST_SETHOLD: begin
                // While set is held the flop must read 1 regardless of d.
                cmp_en  = 1'b1;
                cmp_exp = 1'b1;
                if (!obs_set) begin
                    state_d = GUARD_ZERO ? ST_CHECK : ST_GUARD;
                    guard_d = GUARD_LD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!chk_en) begin
            state_d = ST_IDLE;
            guard_d = '0;
            cmp_en  = 1'b0;
        end
    end

    assign mismatch = cmp_en && (obs_q != cmp_exp);
    assign set_rise = obs_set && !set_prev_q && (state_q != ST_IDLE);

    // Error flag, first-error timestamp and free cycle counter; clear overrides everything.
    always_comb begin
        m_d               = obs_d;
        set_prev_d        = obs_set;
        err_d             = err_q | mismatch;
        first_err_cycle_d = first_err_cycle_q;
        cycle_count_d     = cycle_count_q;
        if (mismatch && !err_q) begin
            first_err_cycle_d = cycle_count_q;
        end
        if (chk_en) begin
            cycle_count_d = cycle_count_q + CW'(1);
        end
        if (clr) begin
            err_d             = 1'b0;
            first_err_cycle_d = '0;
            cycle_count_d     = '0;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q           <= ST_IDLE;
            guard_q           <= '0;
            set_prev_q        <= 1'b0;
            err_q             <= 1'b0;
            first_err_cycle_q <= '0;
            cycle_count_q     <= '0;
        end else begin
            state_q           <= state_d;
            guard_q           <= guard_d;
            set_prev_q        <= set_prev_d;
            err_q             <= err_d;
            first_err_cycle_q <= first_err_cycle_d;
            cycle_count_q     <= cycle_count_d;
        end
    end

    // Reference flop: same async-set behaviour as the flop under check.
    always_ff @(posedge clk or negedge async_reset_n or posedge obs_set) begin
        if (!async_reset_n) begin
            m_q <= 1'b0;
        end else if (obs_set) begin
            m_q <= 1'b1;
        end else begin
            m_q <= m_d;
        end
    end

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .inc           (mismatch),
        .clr           (clr),
        .count         (err_count)
    );

    sat_counter #(.CW(CW)) u_set_cnt (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .inc           (set_rise),
        .clr           (clr),
        .count         (set_count)
    );

    assign err             = err_q;
    assign first_err_cycle = first_err_cycle_q;
    assign state           = state_q;

endmodule

// File: tb/tb_flop_response_checker.sv
// Directed bench for flop_response_checker; one time unit is half a nanosecond.
module tb_flop_response_checker;

    logic clk = 1'b0;
    logic async_reset_n = 1'b1;
    logic chk_en = 1'b0;
    logic clr = 1'b0;
    logic obs_set = 1'b0;
    logic obs_d = 1'b0;
    logic obs_q;
    logic use_model = 1'b1;
    logic forced_q = 1'b0;
    logic model_q;

    logic        err0, err1, err2;
    logic [15:0] ec0, sc0, fec0, ec1, sc1, fec1;
    logic [3:0]  ec2, sc2, fec2;
    logic [1:0]  st0, st1, st2;

    int tests = 0;
    int fails = 0;

    // 20 ns clock period.
    always #20 clk = ~clk;

    // Behavioural dff_async_set standing in for the flop under check.
    always @(posedge clk or posedge obs_set) begin
        if (obs_set) model_q <= 1'b1;
        else         model_q <= obs_d;
    end

    assign obs_q = use_model ? model_q : forced_q;

    flop_response_checker u0 (
        .clk(clk), .async_reset_n(async_reset_n), .chk_en(chk_en), .clr(clr),
        .obs_set(obs_set), .obs_d(obs_d), .obs_q(obs_q),
        .err(err0), .err_count(ec0), .set_count(sc0), .first_err_cycle(fec0), .state(st0)
    );

    flop_response_checker #(.GUARD(3)) u1 (
        .clk(clk), .async_reset_n(async_reset_n), .chk_en(chk_en), .clr(clr),
        .obs_set(obs_set), .obs_d(obs_d), .obs_q(obs_q),
        .err(err1), .err_count(ec1), .set_count(sc1), .first_err_cycle(fec1), .state(st1)
    );

    flop_response_checker #(.CW(4)) u2 (
        .clk(clk), .async_reset_n(async_reset_n), .chk_en(chk_en), .clr(clr),
        .obs_set(obs_set), .obs_d(obs_d), .obs_q(obs_q),
        .err(err2), .err_count(ec2), .set_count(sc2), .first_err_cycle(fec2), .state(st2)
    );

    task automatic test_reset();
        #2 async_reset_n = 1'b0;
        #3;
        tests++; if (st0 !== 2'd0) begin fails++; $display("FAIL reset_st0 got %0d want 0", st0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL reset_err0 got %0b want 0", err0); end
        tests++; if ({ec0, sc0, fec0} !== 48'd0) begin fails++; $display("FAIL reset_cnt0 got %0h want 0", {ec0, sc0, fec0}); end
        tests++; if ({st1, err1, ec1, sc1, fec1} !== 51'd0) begin fails++; $display("FAIL reset_u1 got %0h want 0", {st1, err1, ec1, sc1, fec1}); end
        tests++; if ({st2, err2, ec2, sc2, fec2} !== 15'd0) begin fails++; $display("FAIL reset_u2 got %0h want 0", {st2, err2, ec2, sc2, fec2}); end
        @(negedge clk);
        async_reset_n = 1'b1;
    endtask

    // Enable after reset: state walk and earliest compare with a wrong q.
    task automatic test_enable_guard();
        logic [1:0] exp_st1;
        chk_en = 1'b1;
        use_model = 1'b0;
        forced_q = 1'b1;
        @(negedge clk);
        tests++; if (st0 !== 2'd1) begin fails++; $display("FAIL en_st0_e1 got %0d want 1", st0); end
        @(negedge clk);
        tests++; if (st0 !== 2'd2) begin fails++; $display("FAIL en_st0_e2 got %0d want 2", st0); end
        tests++; if (ec0 !== 16'd0) begin fails++; $display("FAIL en_noguardcmp got %0d want 0", ec0); end
        @(negedge clk);
        tests++; if (ec0 !== 16'd1) begin fails++; $display("FAIL en_firstcmp got %0d want 1", ec0); end
        tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL en_st1_e3 got %0d want 1", st1); end
        @(negedge clk);
        exp_st1 = 2'd2;
        tests++; if (st1 !== exp_st1) begin fails++; $display("FAIL en_st1_e4 got %0d want %0d", st1, exp_st1); end
        tests++; if (ec1 !== 16'd0) begin fails++; $display("FAIL en_u1_guard got %0d want 0", ec1); end
        use_model = 1'b1;
    endtask

    // Correct flop with d every 23 ns and set every 547 ns over 3000 ns.
    task automatic test_model_run();
        obs_d = 1'b0;
        obs_set = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        fork
            begin #1; repeat (130) begin #46 obs_d = ~obs_d; end end
            begin #1; repeat (5) begin #1094 obs_set = ~obs_set; end end
        join
        @(negedge clk);
        @(negedge clk);
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL run_err got %0b want 0", err0); end
        tests++; if (ec0 !== 16'd0) begin fails++; $display("FAIL run_err_count got %0d want 0", ec0); end
        tests++; if (sc0 !== 16'd3) begin fails++; $display("FAIL run_set_count got %0d want 3", sc0); end
        tests++; if (st0 !== 2'd3) begin fails++; $display("FAIL run_state got %0d want 3", st0); end
    endtask

    // Single forced wrong q at cycle_count 40, then a second one that must not move the timestamp.
    task automatic test_first_error();
        obs_set = 1'b0;
        obs_d = 1'b1;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        use_model = 1'b0;
        forced_q = 1'b0;
        @(negedge clk);
        use_model = 1'b1;
        tests++; if (err0 !== 1'b1) begin fails++; $display("FAIL fe_err got %0b want 1", err0); end
        tests++; if (ec0 !== 16'd1) begin fails++; $display("FAIL fe_count got %0d want 1", ec0); end
        tests++; if (fec0 !== 16'd40) begin fails++; $display("FAIL fe_cycle got %0d want 40", fec0); end
        repeat (3) @(negedge clk);
        use_model = 1'b0;
        @(negedge clk);
        use_model = 1'b1;
        tests++; if (ec0 !== 16'd2) begin fails++; $display("FAIL fe_count2 got %0d want 2", ec0); end
        tests++; if (fec0 !== 16'd40) begin fails++; $display("FAIL fe_cycle_kept got %0d want 40", fec0); end
    endtask

    // Set held with q stuck low: both counters move on entry, then one error per cycle.
    task automatic test_sethold();
        logic [15:0] exp_ec;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        obs_set = 1'b1;
        use_model = 1'b0;
        forced_q = 1'b0;
        @(negedge clk);
        tests++; if (st0 !== 2'd3) begin fails++; $display("FAIL sh_state got %0d want 3", st0); end
        tests++; if (ec0 !== 16'd1) begin fails++; $display("FAIL sh_ec_entry got %0d want 1", ec0); end
        tests++; if (sc0 !== 16'd1) begin fails++; $display("FAIL sh_sc_entry got %0d want 1", sc0); end
        tests++; if (err0 !== 1'b1) begin fails++; $display("FAIL sh_err got %0b want 1", err0); end
        tests++; if (fec0 !== 16'd0) begin fails++; $display("FAIL sh_fec got %0d want 0", fec0); end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            exp_ec = 16'(i);
            tests++; if (ec0 !== exp_ec) begin fails++; $display("FAIL sh_ec_step got %0d want %0d", ec0, exp_ec); end
        end
        forced_q = 1'b1;
        @(negedge clk);
        tests++; if (ec0 !== 16'd4) begin fails++; $display("FAIL sh_ec_hold got %0d want 4", ec0); end
        tests++; if (sc0 !== 16'd1) begin fails++; $display("FAIL sh_sc_hold got %0d want 1", sc0); end
    endtask

    // Reset in the middle of SETHOLD clears everything before any clock edge.
    task automatic test_reset_mid_sethold();
        #5 async_reset_n = 1'b0;
        #1;
        tests++; if (st0 !== 2'd0) begin fails++; $display("FAIL mr_state got %0d want 0", st0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL mr_err got %0b want 0", err0); end
        tests++; if ({ec0, sc0, fec0} !== 48'd0) begin fails++; $display("FAIL mr_counts got %0h want 0", {ec0, sc0, fec0}); end
        @(negedge clk);
        obs_set = 1'b0;
        use_model = 1'b1;
        @(negedge clk);
        async_reset_n = 1'b1;
    endtask

    // GUARD=3 instance: wrong q in the three guard cycles after set release is ignored.
    task automatic test_guard_release();
        obs_d = 1'b0;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        obs_set = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (st1 !== 2'd3) begin fails++; $display("FAIL gr_sethold got %0d want 3", st1); end
        tests++; if (sc1 !== 16'd1) begin fails++; $display("FAIL gr_set_count got %0d want 1", sc1); end
        obs_set = 1'b0;
        @(negedge clk);
        tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL gr_guard got %0d want 1", st1); end
        use_model = 1'b0;
        forced_q = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (st1 !== 2'd2) begin fails++; $display("FAIL gr_check got %0d want 2", st1); end
        tests++; if ({err1, ec1} !== 17'd0) begin fails++; $display("FAIL gr_masked got %0h want 0", {err1, ec1}); end
        @(negedge clk);
        tests++; if (err1 !== 1'b1) begin fails++; $display("FAIL gr_err got %0b want 1", err1); end
        tests++; if (ec1 !== 16'd1) begin fails++; $display("FAIL gr_count got %0d want 1", ec1); end
        use_model = 1'b1;
    endtask

    // CW=4 instance: error count saturates at 15; clear beats a same-cycle mismatch.
    task automatic test_saturation();
        logic [3:0] exp4;
        obs_d = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        use_model = 1'b0;
        forced_q = 1'b0;
        @(negedge clk);
        tests++; if ({err2, ec2} !== 5'd0) begin fails++; $display("FAIL sat_clr_prio got %0h want 0", {err2, ec2}); end
        clr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp4 = (i > 15) ? 4'd15 : 4'(i);
            tests++; if (ec2 !== exp4) begin fails++; $display("FAIL sat_count got %0d want %0d", ec2, exp4); end
        end
        tests++; if (err2 !== 1'b1) begin fails++; $display("FAIL sat_err got %0b want 1", err2); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests++; if (ec2 !== 4'd0) begin fails++; $display("FAIL sat_clear_count got %0d want 0", ec2); end
        tests++; if (err2 !== 1'b0) begin fails++; $display("FAIL sat_clear_err got %0b want 0", err2); end
        use_model = 1'b1;
    endtask

    // Disabled checker ignores mismatches and set edges, then re-arms through GUARD.
    task automatic test_idle();
        chk_en = 1'b0;
        clr = 1'b1;
        use_model = 1'b0;
        forced_q = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        tests++; if (st0 !== 2'd0) begin fails++; $display("FAIL idle_state got %0d want 0", st0); end
        obs_set = 1'b1;
        @(negedge clk);
        obs_set = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({err0, ec0} !== 17'd0) begin fails++; $display("FAIL idle_nocmp got %0h want 0", {err0, ec0}); end
        tests++; if (sc0 !== 16'd0) begin fails++; $display("FAIL idle_noset got %0d want 0", sc0); end
        chk_en = 1'b1;
        use_model = 1'b1;
        @(negedge clk);
        tests++; if (st0 !== 2'd1) begin fails++; $display("FAIL idle_rearm_guard got %0d want 1", st0); end
        @(negedge clk);
        tests++; if (st0 !== 2'd2) begin fails++; $display("FAIL idle_rearm_check got %0d want 2", st0); end
    endtask

    initial begin
        test_reset();
        test_enable_guard();
        test_model_run();
        test_first_error();
        test_sethold();
        test_reset_mid_sethold();
        test_guard_release();
        test_saturation();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: sequence still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flop_response_checker.md
FLOP_RESPONSE_CHECKER -- requirements
Module: flop_response_checker

Interface
REQ-001 SHALL have parameter GUARD, default 1, which is the number of compare cycles skipped after check enable or set release (range 0-15).
REQ-002 SHALL have parameter CW, default 16, which is the width of all counters.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port async_reset_n, input, width 1: the asynchronous, active-low reset.
REQ-005 SHALL have port chk_en, input, width 1: enables checking when high.
REQ-006 SHALL have port clr, input, width 1: synchronous clear of counters and the error flag.
REQ-007 SHALL have port obs_set, input, width 1: the observed async_set of the flop under check.
REQ-008 SHALL have port obs_d, input, width 1: the observed d of the flop under check.
REQ-009 SHALL have port obs_q, input, width 1: the observed q of the flop under check.
REQ-010 SHALL have port err, output, width 1: sticky mismatch flag.
REQ-011 SHALL have port err_count, output, width CW: saturating mismatch count.
REQ-012 SHALL have port set_count, output, width CW: saturating count of obs_set rising events.
REQ-013 SHALL have port first_err_cycle, output, width CW: the cycle_count value at the first mismatch.
REQ-014 SHALL have port state, output, width 2: the current FSM state.

Function
REQ-015 SHALL hold a reference model flop m_q, asynchronously set to 1 by obs_set high, else loading obs_d on each clk rising edge.
REQ-016 SHALL treat a compare as obs_q (sampled at the edge) != m_q (pre-edge value).
REQ-017 SHALL implement the FSM states IDLE=0, GUARD=1, CHECK=2, SETHOLD=3.
REQ-018 SHALL transition to IDLE from any state whenever chk_en=0; compares are disabled in IDLE.
REQ-019 SHALL go from IDLE to GUARD when chk_en=1, loading the guard counter with GUARD; if GUARD=0, it SHALL go directly to CHECK.
REQ-020 SHALL decrement the guard counter in GUARD and enter CHECK on the cycle it reaches 0; no compares occur in GUARD.
REQ-021 SHALL compare every cycle in CHECK, and SHALL enter SETHOLD when obs_set is sampled at 1.
REQ-022 SHALL, in SETHOLD, compare obs_q against the constant 1 and, on obs_set sampled at 0, enter GUARD (reload) or CHECK if GUARD=0.
REQ-023 SHALL increment set_count on each sampled 0->1 transition of obs_set, in any non-IDLE state.
REQ-024 SHALL, on a mismatch, set err, increment err_count, and capture first_err_cycle only when err was previously 0.
REQ-025 SHALL run a free cycle_count (CW bits, wrapping) while chk_en=1.
REQ-026 SHALL saturate err_count and set_count at all-ones; they SHALL never wrap.
REQ-027 SHALL, when clr=1, zero err, err_count, set_count, first_err_cycle and cycle_count next edge; clr SHALL take priority over a same-cycle mismatch; FSM state SHALL be unaffected.
REQ-028 SHALL evaluate a mismatch and obs_set rising in the same cycle with both counters updated, and the state SHALL go to SETHOLD.
REQ-029 SHALL have one-cycle output latency: counters and err reflect a compare on the edge that performs it.

Reset
REQ-030 SHALL, on async_reset_n=0, immediately force state=IDLE, m_q=0, err=0, and all counters, the guard counter and first_err_cycle to 0.
REQ-031 SHALL release reset synchronously to clk; the first compare SHALL occur no earlier than GUARD+1 edges after reset release with chk_en=1.
REQ-032 SHALL discard an in-progress GUARD/SETHOLD when reset is asserted mid-operation, with no partial count retained.

Structure
REQ-033 SHALL place the state encoding enum and the default CW/GUARD constants in package flop_chk_pkg.
REQ-034 SHALL implement the counters with a single sub-module sat_counter (CW-wide, saturating, inc/clr inputs), instantiated twice.

Verification
REQ-035 SHALL verify that, for a correct dff_async_set driven with clk period 20, d toggling every 23, and set toggling every 547 for 3000 ns, the bench sees err=0, err_count=0, and set_count=3.
REQ-036 SHALL verify that forcing obs_q=0 for one cycle in CHECK at cycle_count=40 yields err=1, err_count=1, and first_err_cycle=40.
REQ-037 SHALL verify that, with obs_set=1 and obs_q=0, the FSM reaches SETHOLD and err_count increments every cycle while the mismatch persists.
REQ-038 SHALL verify that, with GUARD=3, a wrong obs_q in the 3 cycles after set release causes no error, and the same error on the 4th cycle gives err_count=1.
REQ-039 SHALL verify that, with CW=4 and 20 forced mismatches, err_count=15 (saturated); clr=1 then gives err_count=0 and err=0.
REQ-040 SHALL verify that asserting async_reset_n=0 mid-SETHOLD gives state=0 and all outputs 0 within the same cycle, without waiting for clk.
